mmio_uart_tx: RTL and testbench

- Memory-mapped console transmitter; the responder side of the CPU data-memory bus (Address / Wr / Datain / Dataout).
- Sits beside the data memory and decodes a 3-word window at BASE_ADDR.
- CPU stores to that window push bytes into a FIFO. A serializer drains the FIFO as 8N1 UART frames on tx.
- CPU loads from the window return status and control with the same one-cycle registered read latency as data memory.

---
 rtl/mmio_uart_tx_if.sv | 11 +
 rtl/mmio_uart_tx.sv | 178 +++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_uart_tx_if.sv
// rtl/mmio_uart_tx_if.sv - CPU data-memory bus bundle for the console transmitter
interface mmio_uart_tx_if;
  logic [31:0] Address;
  logic        Wr;
  logic [31:0] Datain;
  logic [31:0] Dataout;
  logic        Hit;

  modport master (output Address, output Wr, output Datain, input Dataout, input Hit);
  modport slave  (input Address, input Wr, input Datain, output Dataout, output Hit);
endinterface

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped FIFO-fed 8N1 UART transmitter (optional UART_TX_IRQ_EN)
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int          DEPTH        = 8,
  parameter int          CLKS_PER_BIT = 4
) (
  input  logic           clock,
  input  logic           reset,
  mmio_uart_tx_if.slave  bus,
  output logic           tx,
  output logic           irq
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int CCW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          state, state_nxt;
  logic [29:0]     word_off;
  logic            sel_tx, sel_st, sel_ctrl;
  logic            wr_tx, wr_st, wr_ctrl;
  logic [CW-1:0]   count;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [7:0]      mem [DEPTH];
  logic            full, empty, push, pop, busy, stop_done, bit_end;
  logic            ovf, txen, done, irqen;
  logic [CCW-1:0]  clk_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic [31:0]     rdata;
  logic            unused_bits;

  // Window decode: offset relative to the base word, three words wide
  assign word_off = bus.Address[31:2] - BASE_ADDR[31:2];
  assign sel_tx   = (word_off == 30'd0);
  assign sel_st   = (word_off == 30'd1);
  assign sel_ctrl = (word_off == 30'd2);
  assign bus.Hit  = sel_tx | sel_st | sel_ctrl;
  assign wr_tx    = bus.Wr & sel_tx;
  assign wr_st    = bus.Wr & sel_st;
  assign wr_ctrl  = bus.Wr & sel_ctrl;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push    = wr_tx & ~full;
  assign bit_end = (clk_cnt == CCW'(CLKS_PER_BIT - 1));

  assign unused_bits = ^{bus.Address[1:0], bus.Datain};

  // FIFO storage; no reset needed, occupancy is tracked by count
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= bus.Datain[7:0];
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Control and sticky overflow; a dropped push sets ovf even if a pop frees space this cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ovf  <= 1'b0;
      txen <= 1'b1;
    end else begin
      if (wr_tx && full)                   ovf <= 1'b1;
      else if (wr_st && bus.Datain[11])    ovf <= 1'b0;
      if (wr_ctrl) txen <= bus.Datain[0];
    end
  end

  // Serializer state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Serializer next-state; the STOP->IDLE->START path gives the one idle cycle between frames
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (txen && !empty)                 state_nxt = S_START;
      S_START: if (bit_end)                        state_nxt = S_DATA;
      S_DATA:  if (bit_end && bit_idx == 3'd7)     state_nxt = S_STOP;
      S_STOP:  if (bit_end)                        state_nxt = S_IDLE;
      default:                                     state_nxt = S_IDLE;
    endcase
  end

  // Serializer outputs; tx is decoded from state so reset forces the line high at once
  always_comb begin
    tx        = 1'b1;
    pop       = 1'b0;
    busy      = (state != S_IDLE);
    stop_done = 1'b0;
    case (state)
      S_IDLE:  pop = txen & ~empty;
      S_START: tx  = 1'b0;
      S_DATA:  tx  = shreg[0];
      S_STOP:  stop_done = bit_end;
      default: tx  = 1'b1;
    endcase
  end

  // Bit timing and shift register; the head byte is loaded on the pop
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (state == S_IDLE || bit_end) clk_cnt <= '0;
      else                            clk_cnt <= clk_cnt + 1'b1;
      if (state != S_DATA)            bit_idx <= '0;
      else if (bit_end)               bit_idx <= bit_idx + 1'b1;
      if (pop)                        shreg <= mem[rd_ptr];
      else if (state == S_DATA && bit_end) shreg <= shreg >> 1;
    end
  end

`ifdef UART_TX_IRQ_EN
  logic done_nxt, irqen_nxt;

  // Done/irqen next values; a completing frame wins over a same-cycle clear
  always_comb begin
    done_nxt  = done;
    irqen_nxt = irqen;
    if (stop_done && empty)               done_nxt = 1'b1;
    else if (wr_st && bus.Datain[12])     done_nxt = 1'b0;
    if (wr_ctrl)                          irqen_nxt = bus.Datain[1];
  end

  // Interrupt state; irq is registered from the next values so it tracks done & irqen
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done  <= 1'b0;
      irqen <= 1'b0;
      irq   <= 1'b0;
    end else begin
      done  <= done_nxt;
      irqen <= irqen_nxt;
      irq   <= done_nxt & irqen_nxt;
    end
  end
`else
  assign done  = 1'b0;
  assign irqen = 1'b0;
  assign irq   = 1'b0;
`endif

  // Read mux for the register window
  always_comb begin
    rdata = 32'h0;
    if (sel_st)   rdata = {19'h0, done, ovf, busy, empty, full, 8'(count)};
    if (sel_ctrl) rdata = {30'h0, irqen, txen};
  end

  // Registered read data, one cycle after the address
  always_ff @(posedge clock or posedge reset) begin
    if (reset) bus.Dataout <= 32'h0;
    else       bus.Dataout <= rdata;
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - scoreboard bench for mmio_uart_tx
module tb_mmio_uart_tx;
  localparam logic [31:0] A_TX   = 32'hFFFF_0000;
  localparam logic [31:0] A_ST   = 32'hFFFF_0004;
  localparam logic [31:0] A_CTRL = 32'hFFFF_0008;
  localparam logic [31:0] A_OUT  = 32'hFFFF_000C;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic tx, irq;
  mmio_uart_tx_if bus();

  mmio_uart_tx #(.BASE_ADDR(32'hFFFF_0000), .DEPTH(8), .CLKS_PER_BIT(4)) dut (
    .clock(clock), .reset(reset), .bus(bus.slave), .tx(tx), .irq(irq));

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit mon_en = 1'b1;
  bit irq_seen = 1'b0;
  logic [7:0] exp_q[$];
  int start_q[$];

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (irq) irq_seen <= 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All bus tasks start and end #1 after a rising edge
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.Address = a; bus.Datain = d; bus.Wr = 1'b1;
    @(posedge clock); #1;
    bus.Wr = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.Address = a; bus.Wr = 1'b0;
    @(posedge clock); #1;
    d = bus.Dataout;
  endtask

  task automatic tx_byte(input logic [7:0] b, input bit accept);
    if (accept) exp_q.push_back(b);
    wr(A_TX, {24'h0, b});
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin @(posedge clock); #1; n++; end
    check("drain_timeout", 64'(n < 3000), 64'd1);
    idle(6);
  endtask

  // Frame monitor: decodes tx mid-bit and compares against the scoreboard
  initial begin
    logic prev_tx;
    logic [7:0] b;
    logic [7:0] e;
    bit aborted;
    prev_tx = 1'b1;
    forever begin
      @(negedge clock);
      if (mon_en && !reset && prev_tx && !tx) begin
        start_q.push_back(cyc);
        aborted = 1'b0;
        b = 8'h0;
        repeat (2) @(negedge clock);
        check("start_bit", 64'(tx), 64'd0);
        for (int k = 0; k < 8; k++) begin
          repeat (4) @(negedge clock);
          if (reset) aborted = 1'b1;
          b[k] = tx;
        end
        repeat (4) @(negedge clock);
        check("stop_bit", 64'(tx), 64'd1);
        if (!aborted) begin
          if (exp_q.size() == 0) check("unexpected_frame", {56'h0, b}, 64'h100);
          else begin
            e = exp_q.pop_front();
            check("frame_byte", {56'h0, b}, {56'h0, e});
          end
        end
      end
      prev_tx = tx;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    logic [41:0] wave, exp_wave;
    logic [7:0] sb;
    bus.Address = 32'h0; bus.Wr = 1'b0; bus.Datain = 32'h0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // reset state
    check("rst_dataout", 64'(bus.Dataout), 64'h0);
    check("rst_tx", 64'(tx), 64'd1);
    check("rst_irq", 64'(irq), 64'd0);
    check("rst_hit", 64'(bus.Hit), 64'd0);
    rd(A_ST, d);   check("rst_status", 64'(d), 64'h200);
    rd(A_CTRL, d); check("rst_ctrl", 64'(d), 64'h1);

    // single byte, cycle-accurate waveform
    sb = 8'h55;
    tx_byte(sb, 1'b1);
    for (int i = 0; i < 42; i++) begin @(negedge clock); wave[i] = tx; end
    exp_wave = '1;
    for (int i = 1; i <= 4; i++) exp_wave[i] = 1'b0;
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < 4; j++) exp_wave[5 + 4*k + j] = sb[k];
    check("wave_55", 64'(wave), 64'(exp_wave));
    @(posedge clock); #1;
    idle(2);

    // two bytes, status mid-frame and afterwards
    tx_byte(8'hC3, 1'b1);
    tx_byte(8'h3C, 1'b1);
    idle(8);
    rd(A_ST, d); check("status_mid", 64'(d), 64'h401);
    drain();
    rd(A_ST, d); check("status_after", 64'(d), 64'h200);

    // overflow and ordering
    wr(A_CTRL, 32'h0);
    rd(A_CTRL, d); check("ctrl_off", 64'(d), 64'h0);
    for (int i = 1; i <= 9; i++) tx_byte(8'(i), i <= 8);
    rd(A_ST, d); check("status_ovf", 64'(d), 64'h908);
    start_q.delete();
    wr(A_CTRL, 32'h1);
    drain();
    check("frame_count", 64'(start_q.size()), 64'd8);
    for (int i = 1; i < start_q.size(); i++)
      check("spacing", 64'(start_q[i] - start_q[i-1]), 64'd41);
    rd(A_ST, d); check("status_ovf_kept", 64'(d), 64'hA00);
    wr(A_ST, 32'h800);
    rd(A_ST, d); check("status_ovf_clr", 64'(d), 64'h200);

    // read latency and decode
    bus.Address = A_CTRL; #1;
    check("hit_ctrl", 64'(bus.Hit), 64'd1);
    @(posedge clock); #1;
    check("lat_ctrl", 64'(bus.Dataout), 64'h1);
    bus.Address = A_OUT; #1;
    check("hit_out", 64'(bus.Hit), 64'd0);
    @(posedge clock); #1;
    check("rd_out", 64'(bus.Dataout), 64'h0);
    wr(A_OUT, 32'hFFFF_FFFF);
    rd(A_CTRL, d); check("out_wr_ctrl", 64'(d), 64'h1);
    rd(A_ST, d);   check("out_wr_status", 64'(d), 64'h200);

    // push/pop collision
    wr(A_CTRL, 32'h0);
    tx_byte(8'hA1, 1'b1);
    tx_byte(8'hB2, 1'b1);
    tx_byte(8'hC3, 1'b1);
    rd(A_ST, d); check("status_3", 64'(d), 64'h003);
    wr(A_CTRL, 32'h1);
    tx_byte(8'hD4, 1'b1);
    rd(A_ST, d); check("status_collide", 64'(d), 64'h403);
    drain();

    // reset in the middle of DATA bit 3
    mon_en = 1'b0;
    tx_byte(8'hF0, 1'b0);
    idle(17);
    check("bit3_low", 64'(tx), 64'd0);
    #2 reset = 1'b1;
    #1 check("rst_mid_tx", 64'(tx), 64'd1);
    @(posedge clock); #1 reset = 1'b0;
    rd(A_ST, d);   check("rst_mid_status", 64'(d), 64'h200);
    rd(A_CTRL, d); check("rst_mid_ctrl", 64'(d), 64'h1);
    idle(45);
    check("rst_mid_line", 64'(tx), 64'd1);
    mon_en = 1'b1;

    // interrupt
`ifdef UART_TX_IRQ_EN
    wr(A_CTRL, 32'h3);
    tx_byte(8'hA5, 1'b1);
    check("irq_pre", 64'(irq), 64'd0);
    drain();
    check("irq_set", 64'(irq), 64'd1);
    rd(A_ST, d); check("status_done", 64'(d), 64'h1200);
    wr(A_ST, 32'h1000);
    check("irq_clr", 64'(irq), 64'd0);
    rd(A_ST, d); check("status_done_clr", 64'(d), 64'h200);
`else
    wr(A_CTRL, 32'h3);
    rd(A_CTRL, d); check("ctrl_noirq", 64'(d), 64'h1);
    tx_byte(8'hA5, 1'b1);
    drain();
    rd(A_ST, d); check("status_nodone", 64'(d), 64'h200);
    check("irq_never", 64'(irq_seen), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
